// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Latency counter width; LATENCY is limited to 1..15 so LATENCY-1 always fits.
    localparam int unsigned CNT_W = 4;

    // Arbiter FSM state encodings.
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_BUSY = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    // Requester identifiers.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Control fields latched when an access is accepted.
    typedef struct packed {
        logic owner;
        logic we;
    } arb_cmd_t;

    // The requester that did not win last time.
    function automatic logic other_port(input logic p);
        return (p == PORT_I) ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Counts BUSY cycles of one memory access; done_c flags the final cycle.
module mem_lat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] cnt;

    // Cycle counter: clear wins over enable; never reaches a wrap point.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done_c = enable && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port fixed-latency memory between the fetch (I) and load/store (D) paths.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_grant;
    arb_cmd_t   cmd;
    logic       accept;
    logic       grant;
    logic       grant_we;
    logic       in_busy;
    logic       cnt_done;

    assign in_busy = (state == ARB_BUSY);

    // Next-state and arbitration decision.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        grant     = PORT_I;
        grant_we  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (i_req && d_req) begin
                    accept = 1'b1;
                    grant  = other_port(last_grant);
                end else if (i_req) begin
                    accept = 1'b1;
                    grant  = PORT_I;
                end else if (d_req) begin
                    accept = 1'b1;
                    grant  = PORT_D;
                end
                grant_we = (grant == PORT_D) ? d_we : 1'b0;
                if (accept) begin
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (cnt_done) begin
                    state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // BUSY-cycle counter, restarted on every accept.
    mem_lat_counter #(
        .LATENCY (LATENCY)
    ) u_lat_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (in_busy),
        .done_c (cnt_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch, memory strobes, response data and valid pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_I;
            cmd        <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
            mem_write <= 1'b0;

            if (accept) begin
                last_grant <= grant;
                cmd.owner  <= grant;
                cmd.we     <= grant_we;
                mem_addr   <= (grant == PORT_D) ? d_addr : i_addr;
                if (grant == PORT_D) begin
                    mem_din <= d_wdata;
                end
                // Reads strobe for the whole access, writes only in the first BUSY cycle.
                mem_read   <= !grant_we;
                mem_write  <= grant_we;
                busy       <= 1'b1;
            end

            if (in_busy && cnt_done) begin
                mem_read <= 1'b0;
                if (cmd.owner == PORT_I) begin
                    i_rdata <= mem_dout;
                    i_valid <= 1'b1;
                end else begin
                    d_rdata <= cmd.we ? '0 : mem_dout;
                    d_valid <= 1'b1;
                end
            end

            if (state == ARB_RESP) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
